// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel control-phase interface (sequencer and readout).
// Phase encoding, default array geometry and phase-order helpers.
package pixel_pkg;

    localparam int DEF_PIX_W       = 8;
    localparam int DEF_N_COL       = 2;
    localparam int DEF_CAPTURE_DLY = 2;
    localparam int N_STROBE        = 5;

    typedef enum logic [2:0] {
        PH_NONE,
        PH_ERASE,
        PH_EXPOSE,
        PH_CONVERT,
        PH_READ1,
        PH_READ2
    } phase_t;

    // Strobe bit index 0..4 = erase, expose, convert, read1, read2.
    function automatic phase_t strobe_phase(input int idx);
        case (idx)
            0:       return PH_ERASE;
            1:       return PH_EXPOSE;
            2:       return PH_CONVERT;
            3:       return PH_READ1;
            4:       return PH_READ2;
            default: return PH_NONE;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_ERASE:   return PH_EXPOSE;
            PH_EXPOSE:  return PH_CONVERT;
            PH_CONVERT: return PH_READ1;
            PH_READ1:   return PH_READ2;
            default:    return PH_ERASE;
        endcase
    endfunction

endpackage

// File: rtl/pixel_ramp.sv
// Conversion ramp: code 0 registered at the convert rise, +1 per cycle while convert holds, saturating.
// ramp_en drops on the first cycle convert is sampled low; the code holds its last value.
module pixel_ramp
    import pixel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             convert,
    input  logic             convert_rise,
    output logic             ramp_en,
    output logic [PIX_W-1:0] ramp_code
);

    localparam logic [PIX_W-1:0] CODE_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_en   <= 1'b0;
            ramp_code <= '0;
        end else if (convert_rise) begin
            ramp_en   <= 1'b1;
            ramp_code <= '0;
        end else if (convert) begin
            if (ramp_en && (ramp_code != CODE_MAX))
                ramp_code <= ramp_code + 1'b1;
        end else begin
            ramp_en <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Readout end of the pixel phase interface: order checker, ramp, one-row buffer and pixel stream.
// Stream starts one cycle after capture, one pixel per cycle; out_valid/out_data hold while out_ready is low.
module pixel_readout
    import pixel_pkg::*;
#(
    parameter int N_COL       = DEF_N_COL,
    parameter int PIX_W       = DEF_PIX_W,
    parameter int CAPTURE_DLY = DEF_CAPTURE_DLY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   erase,
    input  logic                   expose,
    input  logic                   convert,
    input  logic                   read1,
    input  logic                   read2,
    input  logic [N_COL*PIX_W-1:0] pix_bus,
    output logic                   row_sel,
    output logic                   ramp_en,
    output logic [PIX_W-1:0]       ramp_code,
    output logic [PIX_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [15:0]            frame_cnt,
    output logic                   seq_error,
    output logic                   overrun
);

    localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int DW = $clog2(CAPTURE_DLY + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N_COL - 1);
    localparam logic [DW-1:0] CAP_AT   = DW'(CAPTURE_DLY);

    logic [N_STROBE-1:0] stb, stb_q, rise;

    assign stb  = {read2, read1, convert, expose, erase};
    assign rise = stb & ~stb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stb_q <= '0;
        else       stb_q <= stb;
    end

    // Order checker: expected phase advances from whatever actually rose, so one
    // out-of-order strobe flags once and the checker follows the new position.
    phase_t exp_q, exp_d;
    logic   order_err, multi_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) exp_q <= PH_ERASE;
        else       exp_q <= exp_d;
    end

    always_comb begin
        exp_d     = exp_q;
        order_err = 1'b0;
        for (int i = 0; i < N_STROBE; i++) begin
            if (rise[i]) begin
                if (exp_q != strobe_phase(i)) order_err = 1'b1;
                exp_d = next_phase(strobe_phase(i));
            end
        end
    end

    assign multi_hi = $countones(stb) > 1;

    // Capture tracking for the most recent read rise.
    logic          pend_q, pend_row_q;
    logic [DW-1:0] dly_q;
    logic          rd_lvl, cap_fire, early_fall;

    assign rd_lvl     = pend_row_q ? read2 : read1;
    assign cap_fire   = pend_q && rd_lvl && (dly_q == CAP_AT);
    assign early_fall = pend_q && !rd_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_row_q <= 1'b0;
            dly_q      <= '0;
            row_sel    <= 1'b0;
        end else if (rise[3] || rise[4]) begin
            pend_q     <= 1'b1;
            pend_row_q <= rise[4];
            row_sel    <= rise[4];
            dly_q      <= DW'(1);
        end else if (pend_q) begin
            if (cap_fire || early_fall) pend_q <= 1'b0;
            else                        dly_q  <= dly_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   seq_error <= 1'b0;
        else if (order_err || multi_hi || early_fall) seq_error <= 1'b1;
    end

    // Row buffer stays full until the posedge of its final column transfer, so a
    // capture landing on that same edge is dropped.
    logic                   buf_full_q, buf_row_q;
    logic [N_COL*PIX_W-1:0] buf_dat_q;
    logic [CW-1:0]          col_q, col_nx;

    assign col_nx = col_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q <= 1'b0;
            buf_row_q  <= 1'b0;
            buf_dat_q  <= '0;
            col_q      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (cap_fire) begin
                if (buf_full_q) begin
                    overrun <= 1'b1;
                end else begin
                    buf_full_q <= 1'b1;
                    buf_row_q  <= pend_row_q;
                    buf_dat_q  <= pix_bus;
                end
            end
            if (!out_valid && buf_full_q) begin
                out_valid <= 1'b1;
                col_q     <= '0;
                out_data  <= buf_dat_q[0 +: PIX_W];
                out_last  <= buf_row_q && (N_COL == 1);
            end else if (out_valid && out_ready) begin
                if (col_q == LAST_COL) begin
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    buf_full_q <= 1'b0;
                    if (out_last) frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    col_q    <= col_nx;
                    out_data <= buf_dat_q[col_nx*PIX_W +: PIX_W];
                    out_last <= buf_row_q && (col_nx == LAST_COL);
                end
            end
        end
    end

    pixel_ramp #(.PIX_W(PIX_W)) u_ramp (
        .clk          (clk),
        .reset        (reset),
        .convert      (convert),
        .convert_rise (rise[2]),
        .ramp_en      (ramp_en),
        .ramp_code    (ramp_code)
    );

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: directed scenario tasks plus a per-cycle scoreboard
// driven by a phase-level model of strobes, captures, ramp and stream.
`timescale 1ns/1ps
module tb_pixel_readout;
    import pixel_pkg::*;

    localparam int NC  = 2;
    localparam int PW  = 8;
    localparam int DLY = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      stb;
    logic [NC*PW-1:0] row0, row1, pix_bus;
    logic            row_sel, ramp_en, out_valid, out_ready, out_last, seq_error, overrun;
    logic [PW-1:0]   ramp_code, out_data;
    logic [15:0]     frame_cnt;

    int checks = 0;
    int errors = 0;
    bit frame_done;

    always #5 clk = ~clk;
    assign pix_bus = row_sel ? row1 : row0;

    pixel_readout #(.N_COL(NC), .PIX_W(PW), .CAPTURE_DLY(DLY)) dut (
        .clk(clk), .reset(reset),
        .erase(stb[0]), .expose(stb[1]), .convert(stb[2]), .read1(stb[3]), .read2(stb[4]),
        .pix_bus(pix_bus), .row_sel(row_sel), .ramp_en(ramp_en), .ramp_code(ramp_code),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_cnt(frame_cnt), .seq_error(seq_error), .overrun(overrun)
    );

    // ---------------- reference model ----------------
    typedef struct packed { logic [PW-1:0] dat; logic last; } pix_t;
    pix_t q[$];
    pix_t xfer_log[$];
    logic [4:0] m_prev;
    int  m_run [5];
    int  m_exp, m_code, m_frames;
    bit  m_err, m_ovr, m_rowsel, m_en, m_fresh;

    task automatic model_reset();
        q.delete();
        m_prev = '0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        m_exp = 0; m_code = 0; m_frames = 0;
        m_err = 0; m_ovr = 0; m_rowsel = 0; m_en = 0; m_fresh = 0;
    endtask

    // Advance the model across one posedge using the inputs it will see.
    task automatic model_step(input bit ev);
        logic [4:0] s, r;
        logic [NC*PW-1:0] w;
        bit full;
        s = stb;
        r = s & ~m_prev;
        full = q.size() > 0;
        m_fresh = 0;
        for (int i = 3; i <= 4; i++) begin
            if (s[i] && m_run[i] == DLY) begin
                if (full) m_ovr = 1;
                else begin
                    w = (i == 4) ? row1 : row0;
                    for (int c = 0; c < NC; c++)
                        q.push_back({w[c*PW +: PW], (i == 4) && (c == NC-1)});
                    m_fresh = 1;
                    full = 1;
                end
            end
            if (!s[i] && m_prev[i] && m_run[i] >= 1 && m_run[i] <= DLY) m_err = 1;
        end
        if (ev && out_ready) begin
            if (q[0].last) m_frames++;
            void'(q.pop_front());
        end
        if ($countones(s) > 1) m_err = 1;
        for (int i = 0; i < 5; i++) begin
            if (r[i]) begin
                if (i != m_exp) m_err = 1;
                m_exp = (i + 1) % 5;
            end
        end
        if (r[4]) m_rowsel = 1;
        else if (r[3]) m_rowsel = 0;
        if (s[2]) begin
            m_en = 1;
            m_code = (m_run[2] > 255) ? 255 : m_run[2];
        end else m_en = 0;
        for (int i = 0; i < 5; i++) m_run[i] = s[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
        m_prev = s;
    endtask

    always begin : mon
        bit ev;
        @(negedge clk);
        #2;
        if (reset) model_reset();
        else begin
            ev = (q.size() > 0) && !m_fresh;
            checks++;
            if (out_valid !== ev) begin
                errors++; $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (out_data !== q[0].dat || out_last !== q[0].last) begin
                    errors++;
                    $display("FAIL pixel t=%0t got %h/%b want %h/%b", $time, out_data, out_last, q[0].dat, q[0].last);
                end
                if (out_ready) xfer_log.push_back({out_data, out_last});
            end
            checks++;
            if (row_sel !== m_rowsel) begin
                errors++; $display("FAIL row_sel t=%0t got %b want %b", $time, row_sel, m_rowsel);
            end
            checks++;
            if (ramp_en !== m_en || ramp_code !== PW'(m_code)) begin
                errors++; $display("FAIL ramp t=%0t got %b/%0d want %b/%0d", $time, ramp_en, ramp_code, m_en, m_code);
            end
            checks++;
            if (seq_error !== m_err || overrun !== m_ovr) begin
                errors++; $display("FAIL flags t=%0t got err %b ovr %b want %b %b", $time, seq_error, overrun, m_err, m_ovr);
            end
            checks++;
            if (frame_cnt !== 16'(m_frames)) begin
                errors++; $display("FAIL frame_cnt t=%0t got %0d want %0d", $time, frame_cnt, m_frames);
            end
            model_step(ev);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input int idx, input int len);
        @(negedge clk);
        stb[idx] = 1'b1;
        repeat (len) @(negedge clk);
        stb[idx] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stb = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        xfer_log.delete();
    endtask

    task automatic do_frame(input logic [NC*PW-1:0] r0, input logic [NC*PW-1:0] r1,
                            input int conv_len, input int rd_len);
        row0 = r0;
        row1 = r1;
        pulse(0, 1 + $urandom_range(0, 2));
        pulse(1, 1 + $urandom_range(0, 3));
        pulse(2, conv_len);
        pulse(3, rd_len);
        pulse(4, rd_len);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() > 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= 2000) begin
            errors++; $display("FAIL drain_timeout queue %0d want 0", q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({row_sel, ramp_en, out_valid, out_last, seq_error, overrun} !== 6'b0) begin
            errors++; $display("FAIL reset_bits got %b want 000000", {row_sel, ramp_en, out_valid, out_last, seq_error, overrun});
        end
        checks++;
        if (ramp_code !== 8'h00 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h %h want 00 00", ramp_code, out_data);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_frame got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_legal_frame();
        logic [35:0] got;
        do_reset();
        out_ready = 1'b1;
        do_frame(16'h3412, 16'h5678, 5, DLY + 1);
        wait_drain();
        got = (xfer_log.size() == 4) ? {xfer_log[0], xfer_log[1], xfer_log[2], xfer_log[3]} : '1;
        checks++;
        if (got !== {8'h12, 1'b0, 8'h34, 1'b0, 8'h78, 1'b0, 8'h56, 1'b1}) begin
            errors++; $display("FAIL legal_stream got %h want 12,34,78,56+last", got);
        end
        checks++;
        if (frame_cnt !== 16'd1 || seq_error !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL legal_status got cnt %0d err %b ovr %b want 1 0 0", frame_cnt, seq_error, overrun);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        out_ready = 1'b1;
        row0 = 16'hA1B2; row1 = 16'hC3D4;
        for (int pass = 0; pass < 2; pass++) begin
            int len;
            len = (pass == 0) ? 256 : 300;
            pulse(0, 2);
            pulse(1, 2);
            @(negedge clk);
            stb[2] = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                checks++;
                if (ramp_en !== 1'b1 || ramp_code !== PW'((i > 255) ? 255 : i)) begin
                    errors++; $display("FAIL ramp_seq len %0d step %0d got %b/%0d want 1/%0d", len, i, ramp_en, ramp_code, (i > 255) ? 255 : i);
                end
            end
            stb[2] = 1'b0;
            @(negedge clk);
            checks++;
            if (ramp_en !== 1'b0 || ramp_code !== 8'd255) begin
                errors++; $display("FAIL ramp_end got %b/%0d want 0/255", ramp_en, ramp_code);
            end
            pulse(3, DLY + 1);
            pulse(4, DLY + 1);
            wait_drain();
        end
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++; $display("FAIL ramp_frames got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] got;
        do_reset();
        out_ready = 1'b0;
        row0 = 16'h3412; row1 = 16'h5678;
        pulse(0, 2);
        pulse(1, 2);
        pulse(2, 4);
        pulse(3, DLY + 1);
        pulse(4, DLY + 1);
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h12) begin
                errors++; $display("FAIL bp_hold got %b/%h want 1/12", out_valid, out_data);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL bp_overrun got %b want 1", overrun);
        end
        out_ready = 1'b1;
        wait_drain();
        got = (xfer_log.size() == 2) ? {xfer_log[0], xfer_log[1]} : '1;
        checks++;
        if (got !== {8'h12, 1'b0, 8'h34, 1'b0}) begin
            errors++; $display("FAIL bp_stream got %h want 12,34 no last", got);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL bp_frames got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_random_frames();
        do_reset();
        for (int f = 0; f < 6; f++) begin
            frame_done = 0;
            fork
                begin
                    do_frame(NC*PW'($urandom), NC*PW'($urandom), $urandom_range(2, 40), DLY + 1 + $urandom_range(0, 3));
                    frame_done = 1;
                end
                while (!frame_done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            join
            out_ready = 1'b1;
            wait_drain();
        end
        checks++;
        if (seq_error !== 1'b0) begin
            errors++; $display("FAIL rand_seq_error got %b want 0", seq_error);
        end
    endtask

    task automatic test_bad_order();
        do_reset();
        out_ready = 1'b1;
        row0 = 16'h3412; row1 = 16'h5678;
        pulse(0, 2);
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b0) begin
            errors++; $display("FAIL order_pre got %b want 0", seq_error);
        end
        stb[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b1) begin
            errors++; $display("FAIL order_edge got %b want 1", seq_error);
        end
        repeat (3) @(negedge clk);
        stb[2] = 1'b0;
        pulse(3, DLY + 1);
        pulse(4, DLY + 1);
        wait_drain();
        checks++;
        if (frame_cnt !== 16'd1 || seq_error !== 1'b1 || xfer_log.size() != 4) begin
            errors++; $display("FAIL order_stream got cnt %0d err %b n %0d want 1 1 4", frame_cnt, seq_error, xfer_log.size());
        end
    endtask

    task automatic test_multi_strobe();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        stb[3] = 1'b1;
        stb[4] = 1'b1;
        @(negedge clk);
        checks++;
        if (seq_error !== 1'b1) begin
            errors++; $display("FAIL multi_strobe got %b want 1", seq_error);
        end
        stb = '0;
        do_reset();
        row0 = 16'hBEEF;
        pulse(0, 2);
        pulse(1, 2);
        pulse(2, 3);
        pulse(3, DLY);
        repeat (2) @(negedge clk);
        checks++;
        if (seq_error !== 1'b1) begin
            errors++; $display("FAIL short_read_err got %b want 1", seq_error);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0 || xfer_log.size() != 0) begin
            errors++; $display("FAIL short_read_capture got vld %b ovr %b n %0d want 0 0 0", out_valid, overrun, xfer_log.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] got;
        do_reset();
        out_ready = 1'b0;
        row0 = 16'h3412; row1 = 16'h5678;
        pulse(0, 2);
        pulse(1, 2);
        pulse(2, 7);
        pulse(3, DLY + 1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre_valid got %b want 1", out_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, ramp_en, row_sel, seq_error, overrun} !== 6'b0 ||
            out_data !== 8'h00 || ramp_code !== 8'h00 || frame_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset got vld %b data %h code %h cnt %0d want all 0", out_valid, out_data, ramp_code, frame_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        xfer_log.delete();
        out_ready = 1'b1;
        do_frame(16'h3412, 16'h5678, 6, DLY + 2);
        wait_drain();
        got = (xfer_log.size() == 4) ? {xfer_log[0], xfer_log[1], xfer_log[2], xfer_log[3]} : '1;
        checks++;
        if (got !== {8'h12, 1'b0, 8'h34, 1'b0, 8'h78, 1'b0, 8'h56, 1'b1} || frame_cnt !== 16'd1) begin
            errors++; $display("FAIL mid_restart got %h cnt %0d want 12,34,78,56+last cnt 1", got, frame_cnt);
        end
    endtask

    initial begin
        stb = '0;
        out_ready = 1'b0;
        row0 = '0;
        row1 = '0;
        frame_done = 0;
        test_reset();
        test_legal_frame();
        test_ramp();
        test_backpressure();
        test_random_frames();
        test_bad_order();
        test_multi_strobe();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
